// File: rtl/shift_pipe_pkg.sv
// Shared definitions for the parametrised shift/delay pipe: the mode encoding.
// The stage record {valid, data} is declared locally by each user because its width follows WIDTH.
package shift_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_SHIFT  = 2'b00,
    MODE_ROTATE = 2'b01,
    MODE_LOAD   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

endpackage

// File: rtl/shift_pipe_param_if.sv
// Control, data and status bundle for shift_pipe_param.
// The master drives control and data; the pipe (slave) returns taps and status.
interface shift_pipe_param_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic                   en;
  logic                   sclr;
  logic [1:0]             mode;
  logic [WIDTH-1:0]       din;
  logic                   din_valid;
  logic [DEPTH*WIDTH-1:0] pload_data;
  logic [WIDTH-1:0]       dout;
  logic                   dout_valid;
  logic [DEPTH*WIDTH-1:0] taps;
  logic [DEPTH-1:0]       taps_valid;
  logic [CW-1:0]          fill_cnt;

  modport master (
    output en, sclr, mode, din, din_valid, pload_data,
    input  dout, dout_valid, taps, taps_valid, fill_cnt
  );

  modport slave (
    input  en, sclr, mode, din, din_valid, pload_data,
    output dout, dout_valid, taps, taps_valid, fill_cnt
  );

endinterface

// File: rtl/shift_pipe_stage.sv
// One pipe stage: WIDTH data bits plus a valid bit.
// Priority is async reset, then clear, then load.
module shift_pipe_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             ld_valid,
  output logic [WIDTH-1:0] q_data,
  output logic             q_valid
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
  } stage_t;

  stage_t q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (ld) begin
      q <= '{valid: ld_valid, data: ld_data};
    end
  end

  assign q_data  = q.data;
  assign q_valid = q.valid;

endmodule

// File: rtl/shift_pipe_param.sv
// Parametrised delay line / shift register with shift, rotate, parallel load and hold,
// stall enable, synchronous clear, per-stage taps and an occupancy count.
module shift_pipe_param
  import shift_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  shift_pipe_param_if.slave bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  mode_e                        mode;
  logic                         ld;
  logic [DEPTH-1:0][WIDTH-1:0]  cur_data;
  logic [DEPTH-1:0]             cur_valid;
  logic [CW-1:0]                fill_q;
  logic [CW-1:0]                fill_nxt;

  assign mode = mode_e'(bus.mode);
  assign ld   = bus.en && (mode != MODE_HOLD);

  // Each stage's source is the pre-edge value of its neighbour, so no stage sees a same-edge update.
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [WIDTH-1:0] nxt_data;
    logic             nxt_valid;

    if (g == 0) begin : g_head
      always_comb begin
        nxt_data  = bus.din;
        nxt_valid = bus.din_valid;
        case (mode)
          MODE_LOAD: begin
            nxt_data  = bus.pload_data[0 +: WIDTH];
            nxt_valid = 1'b1;
          end
          MODE_ROTATE: begin
            nxt_data  = cur_data[DEPTH-1];
            nxt_valid = cur_valid[DEPTH-1];
          end
          default: ;
        endcase
      end
    end else begin : g_body
      always_comb begin
        nxt_data  = cur_data[g-1];
        nxt_valid = cur_valid[g-1];
        if (mode == MODE_LOAD) begin
          nxt_data  = bus.pload_data[g*WIDTH +: WIDTH];
          nxt_valid = 1'b1;
        end
      end
    end

    shift_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (bus.sclr),
      .ld       (ld),
      .ld_data  (nxt_data),
      .ld_valid (nxt_valid),
      .q_data   (cur_data[g]),
      .q_valid  (cur_valid[g])
    );
  end

  always_comb begin
    fill_nxt = fill_q;
    case (mode)
      MODE_SHIFT: fill_nxt = fill_q + CW'(bus.din_valid) - CW'(cur_valid[DEPTH-1]);
      MODE_LOAD:  fill_nxt = CW'(DEPTH);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= '0;
    end else if (bus.sclr) begin
      fill_q <= '0;
    end else if (bus.en) begin
      fill_q <= fill_nxt;
    end
  end

  assign bus.taps       = cur_data;
  assign bus.taps_valid = cur_valid;
  assign bus.dout       = cur_data[DEPTH-1];
  assign bus.dout_valid = cur_valid[DEPTH-1];
  assign bus.fill_cnt   = fill_q;

  // The count is maintained incrementally; it must always agree with the valid bits.
  fill_matches_valid: assert property (@(posedge clk) disable iff (!rst_n)
    fill_q == CW'($countones(cur_valid)));

endmodule

// File: tb/tb_shift_pipe_param.sv
// Directed bench for shift_pipe_param: a WIDTH=8/DEPTH=4 instance driven from a vector table,
// plus hand-written async-reset and DEPTH=1 sequences.
module tb_shift_pipe_param;

  localparam logic [1:0] S = 2'b00;
  localparam logic [1:0] R = 2'b01;
  localparam logic [1:0] L = 2'b10;
  localparam logic [1:0] H = 2'b11;

  typedef struct {
    logic        en;
    logic        sclr;
    logic [1:0]  mode;
    logic [7:0]  din;
    logic        dv;
    logic [31:0] pl;
    logic [31:0] taps;
    logic [3:0]  tv;
    logic [2:0]  fill;
  } vec_t;

  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic [7:0] din;
    logic       dv;
    logic [7:0] pl;
    logic [7:0] dout;
    logic       dval;
  } vec1_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  shift_pipe_param_if #(.WIDTH(8), .DEPTH(4)) bus4 ();
  shift_pipe_param_if #(.WIDTH(8), .DEPTH(1)) bus1 ();

  shift_pipe_param #(.WIDTH(8), .DEPTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  shift_pipe_param #(.WIDTH(8), .DEPTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive4(input logic en, input logic sclr, input logic [1:0] mode,
                        input logic [7:0] din, input logic dv, input logic [31:0] pl);
    bus4.en = en; bus4.sclr = sclr; bus4.mode = mode;
    bus4.din = din; bus4.din_valid = dv; bus4.pload_data = pl;
  endtask

  task automatic check4(input string tag, input logic [31:0] taps, input logic [3:0] tv,
                        input logic [2:0] fill);
    check({tag, " taps"}, bus4.taps, taps);
    check({tag, " taps_valid"}, 32'(bus4.taps_valid), 32'(tv));
    check({tag, " fill_cnt"}, 32'(bus4.fill_cnt), 32'(fill));
    check({tag, " dout"}, 32'(bus4.dout), 32'(taps[31:24]));
    check({tag, " dout_valid"}, 32'(bus4.dout_valid), 32'(tv[3]));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic en, logic sclr, logic [1:0] mode, logic [7:0] din, logic dv,
                              logic [31:0] pl, logic [31:0] taps, logic [3:0] tv, logic [2:0] fill);
    vec_t v;
    v.en = en; v.sclr = sclr; v.mode = mode; v.din = din; v.dv = dv;
    v.pl = pl; v.taps = taps; v.tv = tv; v.fill = fill;
    return v;
  endfunction

  function automatic vec1_t mk1(logic en, logic [1:0] mode, logic [7:0] din, logic dv,
                                logic [7:0] pl, logic [7:0] dout, logic dval);
    vec1_t v;
    v.en = en; v.mode = mode; v.din = din; v.dv = dv; v.pl = pl; v.dout = dout; v.dval = dval;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t  vecs[$];
    vec1_t v1s[$];

    // fill from reset with five valid samples, then clear while stalled
    vecs.push_back(mk(1, 0, S, 8'h11, 1, 0, 32'h0000_0011, 4'b0001, 1));
    vecs.push_back(mk(1, 0, S, 8'h22, 1, 0, 32'h0000_1122, 4'b0011, 2));
    vecs.push_back(mk(1, 0, S, 8'h33, 1, 0, 32'h0011_2233, 4'b0111, 3));
    vecs.push_back(mk(1, 0, S, 8'h44, 1, 0, 32'h1122_3344, 4'b1111, 4));
    vecs.push_back(mk(1, 0, S, 8'h55, 1, 0, 32'h2233_4455, 4'b1111, 4));
    vecs.push_back(mk(0, 1, S, 8'h00, 0, 0, 32'h0000_0000, 4'b0000, 0));
    // bubbles with stalls: valid pattern 1,0,1,1 over en 1,0,1,1,0,1
    vecs.push_back(mk(1, 0, S, 8'hA1, 1, 0, 32'h0000_00A1, 4'b0001, 1));
    vecs.push_back(mk(0, 0, S, 8'hEE, 1, 0, 32'h0000_00A1, 4'b0001, 1));
    vecs.push_back(mk(1, 0, S, 8'hA2, 0, 0, 32'h0000_A1A2, 4'b0010, 1));
    vecs.push_back(mk(1, 0, S, 8'hA3, 1, 0, 32'h00A1_A2A3, 4'b0101, 2));
    vecs.push_back(mk(0, 0, L, 8'hEE, 1, 32'hFFFF_FFFF, 32'h00A1_A2A3, 4'b0101, 2));
    vecs.push_back(mk(1, 0, S, 8'hA4, 1, 0, 32'hA1A2_A3A4, 4'b1011, 3));
    vecs.push_back(mk(1, 0, S, 8'h00, 0, 0, 32'hA2A3_A400, 4'b0110, 2));
    vecs.push_back(mk(1, 0, S, 8'h00, 0, 0, 32'hA3A4_0000, 4'b1100, 2));
    vecs.push_back(mk(1, 0, S, 8'h00, 0, 0, 32'hA400_0000, 4'b1000, 1));
    vecs.push_back(mk(1, 0, S, 8'h00, 0, 0, 32'h0000_0000, 4'b0000, 0));
    // load then rotate a full turn, with a stalled rotate and an enabled hold
    vecs.push_back(mk(1, 0, L, 8'hEE, 1, 32'h4433_2211, 32'h4433_2211, 4'b1111, 4));
    vecs.push_back(mk(1, 0, R, 8'hEE, 0, 0, 32'h3322_1144, 4'b1111, 4));
    vecs.push_back(mk(1, 0, R, 8'hEE, 0, 0, 32'h2211_4433, 4'b1111, 4));
    vecs.push_back(mk(1, 0, R, 8'hEE, 0, 0, 32'h1144_3322, 4'b1111, 4));
    vecs.push_back(mk(0, 0, R, 8'hEE, 0, 0, 32'h1144_3322, 4'b1111, 4));
    vecs.push_back(mk(1, 0, R, 8'hEE, 0, 0, 32'h4433_2211, 4'b1111, 4));
    vecs.push_back(mk(1, 0, H, 8'hFF, 1, 32'h5555_5555, 32'h4433_2211, 4'b1111, 4));
    // clear, fill two, then clear racing a load
    vecs.push_back(mk(1, 1, S, 8'h77, 1, 0, 32'h0000_0000, 4'b0000, 0));
    vecs.push_back(mk(1, 0, S, 8'hBB, 1, 0, 32'h0000_00BB, 4'b0001, 1));
    vecs.push_back(mk(1, 0, S, 8'hCC, 1, 0, 32'h0000_BBCC, 4'b0011, 2));
    vecs.push_back(mk(1, 1, L, 8'hDD, 1, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0000, 0));

    v1s.push_back(mk1(1, S, 8'h5A, 1, 8'h00, 8'h5A, 1));
    v1s.push_back(mk1(1, S, 8'h6B, 0, 8'h00, 8'h6B, 0));
    v1s.push_back(mk1(1, S, 8'h7C, 1, 8'h00, 8'h7C, 1));
    v1s.push_back(mk1(1, R, 8'h00, 0, 8'h00, 8'h7C, 1));
    v1s.push_back(mk1(0, S, 8'h11, 0, 8'h00, 8'h7C, 1));
    v1s.push_back(mk1(1, L, 8'h00, 0, 8'h3D, 8'h3D, 1));
    v1s.push_back(mk1(1, S, 8'h00, 0, 8'h00, 8'h00, 0));

    drive4(0, 0, S, 8'h00, 0, 0);
    bus1.en = 1'b0; bus1.sclr = 1'b0; bus1.mode = S;
    bus1.din = '0; bus1.din_valid = 1'b0; bus1.pload_data = '0;

    repeat (2) @(posedge clk);
    #1;
    check4("reset", 32'h0, 4'b0000, 0);
    check("reset d1 fill_cnt", 32'(bus1.fill_cnt), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive4(vecs[i].en, vecs[i].sclr, vecs[i].mode, vecs[i].din, vecs[i].dv, vecs[i].pl);
      step();
      check4($sformatf("vec%0d", i), vecs[i].taps, vecs[i].tv, vecs[i].fill);
    end

    // asynchronous reset while full: outputs clear before the next clock edge
    drive4(1, 0, L, 8'h00, 0, 32'h1234_5678);
    step();
    check4("preload", 32'h1234_5678, 4'b1111, 4);
    drive4(0, 0, S, 8'h00, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check4("arst", 32'h0, 4'b0000, 0);
    #1 rst_n = 1'b1;
    drive4(1, 0, S, 8'hAA, 1, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check4($sformatf("post_rst%0d", k), 32'h0000_00AA << (8 * k), 4'(1 << k), 1);
      drive4(1, 0, S, 8'h00, 0, 0);
    end
    drive4(0, 0, S, 8'h00, 0, 0);

    for (int i = 0; i < v1s.size(); i++) begin
      bus1.en = v1s[i].en; bus1.mode = v1s[i].mode; bus1.din = v1s[i].din;
      bus1.din_valid = v1s[i].dv; bus1.pload_data = v1s[i].pl;
      step();
      check($sformatf("d1 vec%0d dout", i), 32'(bus1.dout), 32'(v1s[i].dout));
      check($sformatf("d1 vec%0d dout_valid", i), 32'(bus1.dout_valid), 32'(v1s[i].dval));
      check($sformatf("d1 vec%0d fill_cnt", i), 32'(bus1.fill_cnt), 32'(v1s[i].dval));
      check($sformatf("d1 vec%0d taps", i), 32'(bus1.taps), 32'(v1s[i].dout));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
